unsigned_restoring_divider: RTL and testbench

- Multi-cycle unsigned restoring divider; the inverse datapath to the team's unsigned array multiplier.
- Accepts a WIDTH-bit dividend and divisor on a start pulse and iterates one quotient bit per clock.
- Returns quotient and remainder with a one-cycle done pulse.
- Sits beside the multiplier in the arithmetic unit and shares its start/done handshake style.

---
 rtl/unsigned_restoring_divider.sv | 167 ++++++++++++++++
 tb/tb_unsigned_restoring_divider.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/unsigned_restoring_divider.sv
// ---------------------------------------------------------------------------
// unsigned_restoring_divider
//
// Multi-cycle unsigned restoring divider. A start pulse in IDLE latches the
// operands; the datapath then produces one quotient bit per clock, MSB first,
// and presents quotient/remainder with a one-cycle done pulse. A zero divisor
// short-circuits after a single busy cycle with quotient = all ones,
// remainder = dividend and div_by_zero set.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous active-high reset
//   start        in   1      division request, honoured only in IDLE
//   dividend     in   WIDTH  unsigned dividend, sampled on the accepting edge
//   divisor      in   WIDTH  unsigned divisor, sampled on the accepting edge
//   busy         out  1      division in progress
//   done         out  1      one-cycle pulse, results valid
//   quotient     out  WIDTH  result quotient, held until the next result
//   remainder    out  WIDTH  result remainder, held until the next result
//   div_by_zero  out  1      latched divisor was zero; cleared on accept
// ---------------------------------------------------------------------------
module unsigned_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Iteration registers. The partial remainder always stays below the
  // divisor, so WIDTH bits hold it; the extra bit lives only in w_diff.
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_count;
  logic             r_zero;

  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_accept;
  logic             w_busy;
  logic             w_done;
  logic             w_last;

  logic [WIDTH:0]   w_r_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_r_new;
  logic [WIDTH-1:0] w_q_new;

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        // A zero divisor spends exactly one busy cycle before reporting.
        if (r_zero || w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // One restoring step: shift in the next dividend bit, trial-subtract.
  // -------------------------------------------------------------------------
  always_comb begin
    w_r_shift = {r_rem, r_q[WIDTH-1]};
    w_diff    = w_r_shift - {1'b0, r_div};
    w_q_bit   = ~w_diff[WIDTH];
    w_r_new   = w_q_bit ? w_diff[WIDTH-1:0] : w_r_shift[WIDTH-1:0];
    w_q_new   = {r_q[WIDTH-2:0], w_q_bit};
    w_last    = (r_count == CNT_W'(WIDTH - 1));
  end

  // -------------------------------------------------------------------------
  // Datapath and result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div         <= '0;
      r_q           <= '0;
      r_rem         <= '0;
      r_count       <= '0;
      r_zero        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_div         <= divisor;
      r_q           <= dividend;
      r_rem         <= '0;
      r_count       <= '0;
      r_zero        <= (divisor == '0);
      r_div_by_zero <= 1'b0;
    end else if (w_busy) begin
      if (r_zero) begin
        // r_q still holds the untouched dividend here.
        r_quotient    <= '1;
        r_remainder   <= r_q;
        r_div_by_zero <= 1'b1;
      end else begin
        r_q     <= w_q_new;
        r_rem   <= w_r_new;
        r_count <= r_count + CNT_W'(1);
        if (w_last) begin
          r_quotient  <= w_q_new;
          r_remainder <= w_r_new;
        end
      end
    end
  end

  assign busy        = w_busy;
  assign done        = w_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_unsigned_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_unsigned_restoring_divider
//
// Drives directed and random divisions into an 8-bit divider. A reference
// model built on plain / and % tracks, per clock, what busy, done and the
// held results must be; a compare process checks them on every falling edge.
// Directed scenarios additionally check hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_unsigned_restoring_divider;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  unsigned_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // m_k counts clock edges since the accepting edge (0 = idle); the done
  // cycle is m_k == m_lat, busy covers the cycles before it.
  int               m_k   = 0;
  int               m_lat = 0;
  logic [WIDTH-1:0] m_q   = '0;
  logic [WIDTH-1:0] m_r   = '0;
  logic             m_dz  = 1'b0;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] p_r;
  logic             p_dz;
  bit               m_idle;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k  = 0;
      m_q  = '0;
      m_r  = '0;
      m_dz = 1'b0;
    end else begin
      m_idle = (m_k == 0);
      if (!m_idle) begin
        m_k++;
        if (m_k > m_lat) m_k = 0;
        else if (m_k == m_lat) begin
          m_q  = p_q;
          m_r  = p_r;
          m_dz = p_dz;
        end
      end
      if (m_idle && start) begin
        m_k  = 1;
        m_dz = 1'b0;
        if (divisor == '0) begin
          m_lat = 2;
          p_q   = '1;
          p_r   = dividend;
          p_dz  = 1'b1;
        end else begin
          m_lat = WIDTH + 1;
          p_q   = dividend / divisor;
          p_r   = dividend % divisor;
          p_dz  = 1'b0;
        end
      end
    end
  end

  // ---------------- cycle compare ----------------
  always @(negedge clk) begin
    chk("busy",        64'(busy),        64'(m_k >= 1 && m_k < m_lat));
    chk("done",        64'(done),        64'(m_k != 0 && m_k == m_lat));
    chk("quotient",    64'(quotient),    64'(m_q));
    chk("remainder",   64'(remainder),   64'(m_r));
    chk("div_by_zero", 64'(div_by_zero), 64'(m_dz));
  end

  // ---------------- stimulus helpers ----------------
  // Present a request at a falling edge; returns at the first falling edge
  // after the accepting edge with operands scrambled.
  task automatic launch_raw(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
  endtask

  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int guard = 0;
    while ((busy || done) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    launch_raw(a, b);
  endtask

  // Wait for done starting at cycle index n0 and check the latency.
  task automatic wait_done(input int n0, input int exp_lat);
    int n = n0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
  endtask

  task automatic chk_result(input string tag, input int q, input int r, input int dz);
    chk({tag, "_q"},  64'(quotient),    64'(q));
    chk({tag, "_r"},  64'(remainder),   64'(r));
    chk({tag, "_dz"}, 64'(div_by_zero), 64'(dz));
  endtask

  int a_i, b_i, q_i, r_i;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk_result("rst", 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // 100 / 7
    launch(8'd100, 8'd7);
    wait_done(1, 9);
    chk_result("d100_7", 14, 2, 0);

    // 255 / 1 then 5 / 9 with start held through the DONE cycle
    launch(8'd255, 8'd1);
    wait_done(1, 9);
    chk_result("d255_1", 255, 0, 0);
    start    = 1'b1;
    dividend = 8'd5;
    divisor  = 8'd9;
    @(negedge clk);
    launch_raw(8'd5, 8'd9);
    wait_done(1, 9);
    chk_result("d5_9", 0, 5, 0);

    // divide by zero, then a normal division clears the flag
    launch(8'd37, 8'd0);
    wait_done(1, 2);
    chk_result("d37_0", 255, 37, 1);
    launch(8'd200, 8'd16);
    chk("dz_cleared", 64'(div_by_zero), 64'(0));
    wait_done(1, 9);
    chk_result("d200_16", 12, 8, 0);

    // second start mid-RUN is ignored
    launch(8'd200, 8'd3);
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd9;
    @(negedge clk);
    start    = 1'b0;
    wait_done(3, 9);
    chk_result("d200_3", 66, 2, 0);

    // asynchronous reset in the 4th RUN cycle
    launch(8'd250, 8'd6);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk_result("arst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(8'd250, 8'd6);
    wait_done(1, 9);
    chk_result("d250_6", 41, 4, 0);

    // random non-zero divisors
    for (int i = 0; i < 1000; i++) begin
      a_i = int'($urandom_range(0, 255));
      b_i = int'($urandom_range(1, 255));
      launch(WIDTH'(a_i), WIDTH'(b_i));
      wait_done(1, 9);
      q_i = int'(quotient);
      r_i = int'(remainder);
      chk("invariant", 64'(a_i == q_i * b_i + r_i && r_i < b_i), 64'(1));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
